// File: rtl/simmem_release_scheduler.sv
// simmem_release_scheduler: per-slot delay countdown driving the linked-list bank's per-ID release enables.
// Optional stall/high-water statistics ports are built when SIMMEM_RELEASE_SCHED_STATS_EN is defined.
module simmem_release_scheduler #(
    parameter int IDWidth    = 8,
    parameter int NumSlots   = 32,
    parameter int DelayWidth = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [IDWidth-1:0]          in_id_i,
    input  logic [DelayWidth-1:0]       in_delay_i,
    output logic [2**IDWidth-1:0]       release_en_o,
    input  logic                        rel_valid_i,
    input  logic [IDWidth-1:0]          rel_id_i,
    output logic [$clog2(NumSlots):0]   occupancy_o,
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
    output logic [31:0]                 stall_cycles_o,
    output logic [$clog2(NumSlots):0]   max_occupancy_o,
`endif
    output logic                        error_o
);
    localparam int SW = $clog2(NumSlots);
    localparam int OW = SW + 1;
    localparam logic [1:0] S_FREE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_EXP   = 2'd2;

    logic [1:0]            state_q [NumSlots];
    logic [DelayWidth-1:0] cnt_q   [NumSlots];
    logic [IDWidth-1:0]    id_q    [NumSlots];
    logic [OW-1:0]         occ_q;
    logic                  err_q;
    logic                  any_free, rel_hit, accept;
    logic [SW-1:0]         alloc_idx, rel_idx;

    // Downward scans so the lowest matching index is the one left standing.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        rel_hit   = 1'b0;
        rel_idx   = '0;
        for (int s = NumSlots - 1; s >= 0; s--) begin
            if (state_q[s] == S_FREE) begin
                any_free  = 1'b1;
                alloc_idx = SW'(s);
            end
            if (state_q[s] == S_EXP && id_q[s] == rel_id_i) begin
                rel_hit = 1'b1;
                rel_idx = SW'(s);
            end
        end
    end

    always_comb begin
        release_en_o = '0;
        for (int s = 0; s < NumSlots; s++)
            if (state_q[s] == S_EXP) release_en_o[id_q[s]] = 1'b1;
    end

    assign accept      = in_valid_i && any_free;
    assign in_ready_o  = any_free;
    assign occupancy_o = occ_q;
    assign error_o     = err_q;

    // Allocation only hits a FREE slot and release only an EXPIRED one, so the three updates never collide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NumSlots; s++) begin
                state_q[s] <= S_FREE;
                cnt_q[s]   <= '0;
                id_q[s]    <= '0;
            end
            occ_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int s = 0; s < NumSlots; s++) begin
                if (state_q[s] == S_COUNT) begin
                    cnt_q[s] <= cnt_q[s] - 1'b1;
                    if (cnt_q[s] == DelayWidth'(1)) state_q[s] <= S_EXP;
                end
                if (accept && alloc_idx == SW'(s)) begin
                    state_q[s] <= (in_delay_i >= DelayWidth'(2)) ? S_COUNT : S_EXP;
                    cnt_q[s]   <= in_delay_i;
                    id_q[s]    <= in_id_i;
                end
                if (rel_valid_i && rel_hit && rel_idx == SW'(s)) state_q[s] <= S_FREE;
            end
            occ_q <= occ_q + OW'(accept) - OW'(rel_valid_i && rel_hit);
            if (rel_valid_i && !rel_hit) err_q <= 1'b1;
        end
    end

`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
    logic [31:0]   stall_q;
    logic [OW-1:0] max_q;

    assign stall_cycles_o  = stall_q;
    assign max_occupancy_o = max_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            max_q   <= '0;
        end else begin
            if (in_valid_i && !any_free && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (occ_q > max_q) max_q <= occ_q;
        end
    end
`endif
endmodule

// File: tb/tb_simmem_release_scheduler.sv
// tb_simmem_release_scheduler: directed scenarios for simmem_release_scheduler.
// Stats checks are compiled in only when SIMMEM_RELEASE_SCHED_STATS_EN is defined.
module tb_simmem_release_scheduler;
    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [7:0]   in_id_i = '0;
    logic [7:0]   in_delay_i = '0;
    logic [255:0] release_en_o;
    logic         rel_valid_i = 1'b0;
    logic [7:0]   rel_id_i = '0;
    logic [5:0]   occupancy_o;
    logic         error_o;
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
    logic [31:0]  stall_cycles_o;
    logic [5:0]   max_occupancy_o;
`endif
    int checks = 0;
    int failures = 0;

    simmem_release_scheduler #(.IDWidth(8), .NumSlots(32), .DelayWidth(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_id_i(in_id_i), .in_delay_i(in_delay_i),
        .release_en_o(release_en_o), .rel_valid_i(rel_valid_i), .rel_id_i(rel_id_i),
        .occupancy_o(occupancy_o),
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
        .stall_cycles_o(stall_cycles_o), .max_occupancy_o(max_occupancy_o),
`endif
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; rel_valid_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
        checks++; if (release_en_o !== '0) begin failures++; $display("FAIL reset_release got=%h exp=0", release_en_o); end
        checks++; if (occupancy_o !== 6'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
        checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error_o); end
    endtask

    task automatic test_delay5();
        in_valid_i = 1'b1; in_id_i = 8'd3; in_delay_i = 8'd5;
        step();
        in_valid_i = 1'b0;
        checks++; if (occupancy_o !== 6'd1) begin failures++; $display("FAIL d5_occ_after_accept got=%0d exp=1", occupancy_o); end
        checks++; if (release_en_o[3] !== 1'b0) begin failures++; $display("FAIL d5_bit_cycle0 got=%b exp=0", release_en_o[3]); end
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++; if (release_en_o[3] !== (k >= 5)) begin failures++; $display("FAIL d5_bit_cycle%0d got=%b exp=%b", k, release_en_o[3], k >= 5); end
        end
        rel_valid_i = 1'b1; rel_id_i = 8'd3;
        step();
        rel_valid_i = 1'b0;
        checks++; if (release_en_o[3] !== 1'b0) begin failures++; $display("FAIL d5_bit_after_release got=%b exp=0", release_en_o[3]); end
        checks++; if (occupancy_o !== 6'd0) begin failures++; $display("FAIL d5_occ_after_release got=%0d exp=0", occupancy_o); end
        checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL d5_error got=%b exp=0", error_o); end
    endtask

    task automatic test_delay_zero_one();
        for (int d = 0; d <= 1; d++) begin
            in_valid_i = 1'b1; in_id_i = 8'd7; in_delay_i = 8'(d);
            step();
            in_valid_i = 1'b0;
            checks++; if (release_en_o[7] !== 1'b1) begin failures++; $display("FAIL d%0d_bit7 got=%b exp=1", d, release_en_o[7]); end
            rel_valid_i = 1'b1; rel_id_i = 8'd7;
            step();
            rel_valid_i = 1'b0;
            checks++; if (release_en_o[7] !== 1'b0) begin failures++; $display("FAIL d%0d_bit7_released got=%b exp=0", d, release_en_o[7]); end
            checks++; if (occupancy_o !== 6'd0) begin failures++; $display("FAIL d%0d_occ got=%0d exp=0", d, occupancy_o); end
        end
    endtask

    task automatic test_same_id_order();
        in_valid_i = 1'b1; in_id_i = 8'd2; in_delay_i = 8'd10;
        step();
        in_delay_i = 8'd2;
        step();
        in_valid_i = 1'b0;
        checks++; if (release_en_o[2] !== 1'b0) begin failures++; $display("FAIL same_bit_edge1 got=%b exp=0", release_en_o[2]); end
        step();
        checks++; if (release_en_o[2] !== 1'b0) begin failures++; $display("FAIL same_bit_edge2 got=%b exp=0", release_en_o[2]); end
        step();
        checks++; if (release_en_o[2] !== 1'b1) begin failures++; $display("FAIL same_bit_edge3 got=%b exp=1", release_en_o[2]); end
        rel_valid_i = 1'b1; rel_id_i = 8'd2;
        for (int e = 4; e <= 10; e++) begin
            step();
            rel_valid_i = 1'b0;
            checks++; if (release_en_o[2] !== (e >= 10)) begin failures++; $display("FAIL same_bit_edge%0d got=%b exp=%b", e, release_en_o[2], e >= 10); end
        end
        checks++; if (occupancy_o !== 6'd1) begin failures++; $display("FAIL same_occ_mid got=%0d exp=1", occupancy_o); end
        rel_valid_i = 1'b1;
        step();
        rel_valid_i = 1'b0;
        step();
        checks++; if (release_en_o[2] !== 1'b0) begin failures++; $display("FAIL same_bit_final got=%b exp=0", release_en_o[2]); end
        checks++; if (occupancy_o !== 6'd0) begin failures++; $display("FAIL same_occ_final got=%0d exp=0", occupancy_o); end
        checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL same_error got=%b exp=0", error_o); end
    endtask

    task automatic test_back_to_back_full();
        int waited;
        do_reset();
        in_valid_i = 1'b1; in_id_i = 8'd4; in_delay_i = 8'd255;
        for (int i = 0; i < 32; i++) begin
            checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d got=%b exp=1", i, in_ready_o); end
            step();
        end
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready_o); end
        checks++; if (occupancy_o !== 6'd32) begin failures++; $display("FAIL full_occ got=%0d exp=32", occupancy_o); end
        step();
        checks++; if (occupancy_o !== 6'd32) begin failures++; $display("FAIL full_ignored_occ got=%0d exp=32", occupancy_o); end
        in_valid_i = 1'b0;
        waited = 0;
        while (release_en_o[4] !== 1'b1 && waited < 300) begin step(); waited++; end
        checks++; if (release_en_o[4] !== 1'b1) begin failures++; $display("FAIL full_expire_timeout got=%b exp=1", release_en_o[4]); end
        rel_valid_i = 1'b1; rel_id_i = 8'd4;
        in_valid_i = 1'b1; in_id_i = 8'd6; in_delay_i = 8'd3;
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL same_cycle_ready got=%b exp=0", in_ready_o); end
        step();
        rel_valid_i = 1'b0;
        checks++; if (occupancy_o !== 6'd31) begin failures++; $display("FAIL release_occ got=%0d exp=31", occupancy_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL next_ready got=%b exp=1", in_ready_o); end
        step();
        in_valid_i = 1'b0;
        checks++; if (occupancy_o !== 6'd32) begin failures++; $display("FAIL reaccept_occ got=%0d exp=32", occupancy_o); end
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL reaccept_ready got=%b exp=0", in_ready_o); end
    endtask

    task automatic test_error();
        do_reset();
        in_valid_i = 1'b1; in_id_i = 8'd9; in_delay_i = 8'd50;
        step();
        in_valid_i = 1'b0;
        rel_valid_i = 1'b1; rel_id_i = 8'd9;
        step();
        rel_valid_i = 1'b0;
        checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL error_set got=%b exp=1", error_o); end
        checks++; if (occupancy_o !== 6'd1) begin failures++; $display("FAIL error_occ got=%0d exp=1", occupancy_o); end
        step(); step();
        checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL error_sticky got=%b exp=1", error_o); end
        checks++; if (occupancy_o !== 6'd1) begin failures++; $display("FAIL error_occ_later got=%0d exp=1", occupancy_o); end
        do_reset();
        checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL error_cleared got=%b exp=0", error_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid_i = 1'b1; in_delay_i = 8'd100;
        for (int i = 0; i < 5; i++) begin
            in_id_i = 8'(i);
            step();
        end
        in_valid_i = 1'b0;
        checks++; if (occupancy_o !== 6'd5) begin failures++; $display("FAIL mid_occ_before got=%0d exp=5", occupancy_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++; if (occupancy_o !== 6'd0) begin failures++; $display("FAIL mid_occ got=%0d exp=0", occupancy_o); end
        checks++; if (release_en_o !== '0) begin failures++; $display("FAIL mid_release got=%h exp=0", release_en_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", in_ready_o); end
    endtask

`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (stall_cycles_o !== 32'd0) begin failures++; $display("FAIL stats_reset_stall got=%0d exp=0", stall_cycles_o); end
        in_valid_i = 1'b1; in_id_i = 8'd1; in_delay_i = 8'd255;
        for (int i = 0; i < 32; i++) step();
        for (int i = 0; i < 3; i++) step();
        in_valid_i = 1'b0;
        checks++; if (stall_cycles_o !== 32'd3) begin failures++; $display("FAIL stats_stall got=%0d exp=3", stall_cycles_o); end
        checks++; if (max_occupancy_o !== 6'd32) begin failures++; $display("FAIL stats_max_occ got=%0d exp=32", max_occupancy_o); end
        do_reset();
        checks++; if (max_occupancy_o !== 6'd0) begin failures++; $display("FAIL stats_max_reset got=%0d exp=0", max_occupancy_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_delay5();
        test_delay_zero_one();
        test_same_id_order();
        test_back_to_back_full();
        test_error();
        test_reset_mid();
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
